// File: rtl/mul_sequencer.sv
// Radix-2 shift-add sequencer for mul/mulh/mulhu. It stalls the core while it
// computes, then presents the result for a single writeback cycle.
module mul_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [3:0]      i_aluop,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_stall,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_count;
  logic [2*XLEN-1:0]   r_product;
  logic [XLEN-1:0]     r_mcand;
  logic [XLEN-1:0]     r_mplier;
  logic                r_neg;
  logic                r_isMulLow;
  logic                r_busy;
  logic                r_done;
  logic [XLEN-1:0]     r_result;

  logic                w_isMul;
  logic                w_isMulh;
  logic                w_accept;
  logic [XLEN-1:0]     w_absA;
  logic [XLEN-1:0]     w_absB;
  logic [2*XLEN-1:0]   w_addend;
  logic [2*XLEN-1:0]   w_fixed;

  assign w_isMulh = (i_aluop == 4'b0110);
  assign w_isMul  = i_start && ((i_aluop == 4'b0101) || w_isMulh || (i_aluop == 4'b0111));
  assign w_accept = w_isMul && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Magnitude of the most negative value wraps back onto itself, which is
  // exactly the unsigned magnitude we want.
  assign w_absA = (w_isMulh && i_a[XLEN-1]) ? -i_a : i_a;
  assign w_absB = (w_isMulh && i_b[XLEN-1]) ? -i_b : i_b;

  assign w_addend = r_mplier[0] ? ({{XLEN{1'b0}}, r_mcand} << r_count) : '0;
  assign w_fixed  = r_neg ? -r_product : r_product;

  assign o_stall  = w_accept || (r_state == S_CALC) || (r_state == S_FIX);
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_product  <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_neg      <= 1'b0;
      r_isMulLow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state    <= S_CALC;
            r_busy     <= 1'b1;
            r_count    <= '0;
            r_product  <= '0;
            r_mcand    <= w_absA;
            r_mplier   <= w_absB;
            r_neg      <= w_isMulh && (i_a[XLEN-1] ^ i_b[XLEN-1]);
            r_isMulLow <= (i_aluop == 4'b0101);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_product <= r_product + w_addend;
          r_mplier  <= r_mplier >> 1;
          r_count   <= r_count + CW'(1);
          if (r_count == CW'(XLEN - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          // Sign is applied once to the full-width magnitude product.
          r_product <= w_fixed;
          r_result  <= r_isMulLow ? w_fixed[XLEN-1:0] : w_fixed[2*XLEN-1:XLEN];
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
